div_sequencer: RTL and testbench

//  Multi-cycle controller and radix-2 restoring datapath for MIPS DIV/DIVU in the execute stage.

---
 rtl/div_sequencer_if.sv | 26 ++
 rtl/div_sequencer.sv | 130 +++++++++++++
 tb/tb_div_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// Operand/result handshake between the execute stage and the DIV/DIVU sequencer.
// master drives the request side; slave is the divider.
interface div_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             ext_stall;
  logic             flush;
  logic             div_stall;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_div, opa, opb, ext_stall, flush,
    input  div_stall, result_valid, hi, lo
  );

  modport slave (
    input  start, signed_div, opa, opb, ext_stall, flush,
    output div_stall, result_valid, hi, lo
  );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle, stalls the pipeline
// while busy and holds HI/LO in DONE until the execute stage is released.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             resetn,
  div_sequencer_if.slave  bus_io
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvsr_q, dvsr_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [WIDTH:0]    shifted, trial;
  logic [WIDTH-1:0]  quo_nxt, rem_nxt;

  always_comb begin
    a_neg = bus_io.signed_div & bus_io.opa[WIDTH-1];
    b_neg = bus_io.signed_div & bus_io.opb[WIDTH-1];
    abs_a = a_neg ? (~bus_io.opa + 1'b1) : bus_io.opa;
    abs_b = b_neg ? (~bus_io.opb + 1'b1) : bus_io.opb;

    // Remainder is always below the divisor, so one extra bit covers the shifted value.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    quo_nxt = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (bus_io.flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            quo_d     = abs_a;
            dvsr_d    = abs_b;
            rem_d     = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            count_d   = '0;
            if (bus_io.opb == '0) begin
              state_d = StDone;
              lo_d    = {WIDTH{1'b1}};
              hi_d    = bus_io.opa;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          rem_d   = rem_nxt;
          quo_d   = quo_nxt;
          count_d = count_q + 1'b1;
          if (count_q == CntW'(WIDTH - 1)) begin
            state_d = StDone;
            lo_d    = neg_quo_q ? (~quo_nxt + 1'b1) : quo_nxt;
            hi_d    = neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;
          end
        end
        StDone: begin
          if (!bus_io.ext_stall) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Low in DONE so the instruction in E can advance on the DONE->IDLE edge.
  assign bus_io.div_stall    = ~bus_io.flush &
                               (((state_q == StIdle) & bus_io.start) | (state_q == StCalc));
  assign bus_io.result_valid = (state_q == StDone);
  assign bus_io.hi           = hi_q;
  assign bus_io.lo           = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus randomized divisions
// compared against plain integer arithmetic.
module tb_div_sequencer;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(W)) dif ();

  div_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus_io (dif)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // MIPS semantics: truncating division, remainder takes dividend sign, /0 gives lo=~0, hi=a.
  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
    logic [31:0] exp_q, exp_r;
    int n;
    ref_div(sgn, a, b, exp_q, exp_r);
    @(negedge clk);
    dif.start      = 1'b1;
    dif.signed_div = sgn;
    dif.opa        = a;
    dif.opb        = b;
    #1;
    check_eq({tag, ".stall0"}, dif.div_stall, 1);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!dif.div_stall) break;
      n++;
    end
    check_eq({tag, ".stall_len"}, n, (b == 32'd0) ? 1 : W + 1);
    check_eq({tag, ".valid"}, dif.result_valid, 1);
    check_eq({tag, ".lo"}, dif.lo, exp_q);
    check_eq({tag, ".hi"}, dif.hi, exp_r);
    // New instruction in E; operand changes must not disturb the held result.
    dif.start      = 1'b0;
    dif.opa        = $urandom;
    dif.opb        = $urandom;
    dif.signed_div = ~sgn;
    dif.ext_stall  = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, ".held_valid"}, dif.result_valid, 1);
      check_eq({tag, ".held_lo"}, dif.lo, exp_q);
      check_eq({tag, ".held_hi"}, dif.hi, exp_r);
    end
    dif.ext_stall = 1'b0;
    @(negedge clk);
    check_eq({tag, ".idle_valid"}, dif.result_valid, 0);
    check_eq({tag, ".idle_stall"}, dif.div_stall, 0);
    last_q = exp_q;
    last_r = exp_r;
  endtask

  initial begin
    bit          sgn;
    logic [31:0] a, b;
    int          sel;

    resetn         = 1'b0;
    dif.start      = 1'b0;
    dif.signed_div = 1'b0;
    dif.opa        = '0;
    dif.opb        = '0;
    dif.ext_stall  = 1'b0;
    dif.flush      = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset.valid", dif.result_valid, 0);
    check_eq("reset.stall", dif.div_stall, 0);
    check_eq("reset.hi", dif.hi, 0);
    check_eq("reset.lo", dif.lo, 0);
    resetn = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
    check_eq("divu_100_7.lo_const", last_q, 32'd14);
    check_eq("divu_100_7.hi_const", last_r, 32'd2);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
    run_div(1'b0, 32'h1234, 32'd0, 0, "divz");
    run_div(1'b1, 32'd100, 32'd7, 5, "hold5");

    // Flush at CALC count 10: no stall that cycle, back to IDLE, hi/lo untouched.
    @(negedge clk);
    dif.start      = 1'b1;
    dif.signed_div = 1'b0;
    dif.opa        = 32'd1000;
    dif.opb        = 32'd3;
    repeat (11) @(negedge clk);
    dif.flush = 1'b1;
    #1;
    check_eq("flush.stall", dif.div_stall, 0);
    @(negedge clk);
    dif.flush = 1'b0;
    #1;
    check_eq("flush.valid", dif.result_valid, 0);
    check_eq("flush.restart_stall", dif.div_stall, 1);
    check_eq("flush.lo", dif.lo, last_q);
    check_eq("flush.hi", dif.hi, last_r);
    dif.start = 1'b0;
    run_div(1'b0, 32'd1000, 32'd3, 0, "post_flush");

    // Flush in the accept cycle: nothing is accepted.
    @(negedge clk);
    dif.start = 1'b1;
    dif.flush = 1'b1;
    #1;
    check_eq("flush_acc.stall", dif.div_stall, 0);
    @(negedge clk);
    dif.start = 1'b0;
    dif.flush = 1'b0;
    @(negedge clk);
    check_eq("flush_acc.no_calc", dif.div_stall, 0);
    check_eq("flush_acc.valid", dif.result_valid, 0);

    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "overflow");
    check_eq("overflow.lo_const", last_q, 32'h8000_0000);

    // Reset mid-CALC.
    @(negedge clk);
    dif.start      = 1'b1;
    dif.signed_div = 1'b0;
    dif.opa        = 32'hDEAD_BEEF;
    dif.opb        = 32'd5;
    repeat (6) @(negedge clk);
    resetn    = 1'b0;
    dif.start = 1'b0;
    @(negedge clk);
    check_eq("midreset.valid", dif.result_valid, 0);
    check_eq("midreset.stall", dif.div_stall, 0);
    check_eq("midreset.hi", dif.hi, 0);
    check_eq("midreset.lo", dif.lo, 0);
    resetn = 1'b1;

    for (int k = 0; k < 24; k++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      unique case (sel)
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 15));
        4: begin
          a = 32'h8000_0000;
          b = $urandom;
        end
        default: b = $urandom;
      endcase
      run_div(sgn, a, b, $urandom_range(0, 3), $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
